// File: rtl/cell_collector.sv
// cell_collector: arbitrates 16 cell injection requests onto 7 router buffer
// channels and forwards each bound cell's serial message, tagged with its
// source address, into the bound buffer.
//
// Optional feature: define CELL_COLLECTOR_PARITY_EN to expect one trailing
// even-parity bit per message (checked, not forwarded, reported on bufErr).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cellReq[0:15]   per-cell injection request (level)
//   cellIn[0:15]    per-cell serial message bit
//   cellAck[0:15]   one-cycle grant pulse to a cell
//   bufFree[0:6]    buffer k can accept a new message
//   bufBit[0:6]     serial bit to buffer k
//   bufVal[0:6]     bufBit[k] valid this cycle
//   bufAddr[27:0]   source cell of channel k in bits [4k+3:4k]
//   bufErr[0:6]     parity-error pulse (constant 0 without parity)
module cell_collector #(
    parameter int unsigned MSG_LEN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:15] cellReq,
    input  logic [0:15] cellIn,
    output logic [0:15] cellAck,
    input  logic [0:6]  bufFree,
    output logic [0:6]  bufBit,
    output logic [0:6]  bufVal,
    output logic [27:0] bufAddr,
    output logic [0:6]  bufErr
);

    localparam int unsigned N_CELL = 16;
    localparam int unsigned N_CH   = 7;
    localparam int unsigned AW     = 4;
    localparam int unsigned CW     = $clog2(MSG_LEN + 1);
`ifdef CELL_COLLECTOR_PARITY_EN
    localparam int unsigned XFER_LEN = MSG_LEN + 1;
`else
    localparam int unsigned XFER_LEN = MSG_LEN;
`endif
    localparam logic [CW-1:0] LAST = CW'(XFER_LEN - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_XFER} ch_state_e;

    ch_state_e       state_q [N_CH];
    ch_state_e       state_d [N_CH];
    logic [CW-1:0]   cnt_q   [N_CH];
    logic [CW-1:0]   cnt_d   [N_CH];
    logic [27:0]     addr_q, addr_d;
    logic [AW-1:0]   rr_q, rr_d;
    logic [0:15]     ack_q, ack_d;
    logic [0:6]      bit_q, bit_d;
    logic [0:6]      val_q, val_d;
`ifdef CELL_COLLECTOR_PARITY_EN
    logic [0:6]      par_q, par_d;
    logic [0:6]      err_q, err_d;
`endif

    logic [0:15]     bound;
    logic            win_found;
    logic [AW-1:0]   win_idx;
    logic [AW-1:0]   cand;
    logic            granted;
    logic [AW-1:0]   src;
    logic            smp;

    // Next-state: per-channel sequencing, round-robin arbitration, binding
    always_comb begin
        for (int unsigned k = 0; k < N_CH; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
        end
        addr_d    = addr_q;
        rr_d      = rr_q;
        ack_d     = '0;
        bit_d     = '0;
        val_d     = '0;
`ifdef CELL_COLLECTOR_PARITY_EN
        par_d     = par_q;
        err_d     = '0;
`endif
        bound     = '0;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        granted   = 1'b0;
        src       = '0;
        smp       = 1'b0;

        // A cell stays bound through its channel's final sample edge
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (state_q[k] != ST_IDLE) begin
                bound[addr_q[4*k +: 4]] = 1'b1;
            end
        end

        for (int unsigned k = 0; k < N_CH; k++) begin
            src = addr_q[4*k +: 4];
            smp = cellIn[src];
            case (state_q[k])
                ST_ACK: begin
                    state_d[k] = ST_XFER;
                    cnt_d[k]   = '0;
`ifdef CELL_COLLECTOR_PARITY_EN
                    par_d[k]   = 1'b0;
`endif
                end
                ST_XFER: begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
`ifdef CELL_COLLECTOR_PARITY_EN
                    if (cnt_q[k] == CW'(MSG_LEN)) begin
                        err_d[k] = par_q[k] ^ smp;
                    end else begin
                        bit_d[k] = smp;
                        val_d[k] = 1'b1;
                        par_d[k] = par_q[k] ^ smp;
                    end
`else
                    bit_d[k] = smp;
                    val_d[k] = 1'b1;
`endif
                    if (cnt_q[k] == LAST) begin
                        state_d[k] = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end

        // Round-robin winner search starting at rr_q
        for (int unsigned i = 0; i < N_CELL; i++) begin
            cand = rr_q + AW'(i);
            if (!win_found && cellReq[cand] && !bound[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end

        // Lowest free channel; a channel on its final sample is reusable now
        if (win_found) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (!granted && bufFree[k] &&
                    (state_q[k] == ST_IDLE ||
                     (state_q[k] == ST_XFER && cnt_q[k] == LAST))) begin
                    granted        = 1'b1;
                    state_d[k]     = ST_ACK;
                    addr_d[4*k +: 4] = win_idx;
                end
            end
        end

        if (granted) begin
            ack_d[win_idx] = 1'b1;
            rr_d           = win_idx + AW'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                state_q[k] <= ST_IDLE;
                cnt_q[k]   <= '0;
            end
            addr_q <= '0;
            rr_q   <= '0;
            ack_q  <= '0;
            bit_q  <= '0;
            val_q  <= '0;
`ifdef CELL_COLLECTOR_PARITY_EN
            par_q  <= '0;
            err_q  <= '0;
`endif
        end else begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            addr_q <= addr_d;
            rr_q   <= rr_d;
            ack_q  <= ack_d;
            bit_q  <= bit_d;
            val_q  <= val_d;
`ifdef CELL_COLLECTOR_PARITY_EN
            par_q  <= par_d;
            err_q  <= err_d;
`endif
        end
    end

    assign cellAck = ack_q;
    assign bufBit  = bit_q;
    assign bufVal  = val_q;
    assign bufAddr = addr_q;
`ifdef CELL_COLLECTOR_PARITY_EN
    assign bufErr  = err_q;
`else
    assign bufErr  = '0;
`endif

endmodule

// File: tb/tb_cell_collector.sv
// Self-checking bench for cell_collector: randomized and directed request
// traffic, behavioural cells that serialise messages after their grant, a
// time-stamped reference model feeding a scoreboard queue, and a monitor.
module tb_cell_collector;

    localparam int MSG_LEN = 32;
`ifdef CELL_COLLECTOR_PARITY_EN
    localparam int XL = MSG_LEN + 1;
`else
    localparam int XL = MSG_LEN;
`endif

    logic        clk;
    logic        rst_n;
    logic [0:15] cellReq;
    logic [0:15] cellIn;
    logic [0:15] cellAck;
    logic [0:6]  bufFree;
    logic [0:6]  bufBit;
    logic [0:6]  bufVal;
    logic [27:0] bufAddr;
    logic [0:6]  bufErr;

    cell_collector #(.MSG_LEN(MSG_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .cellReq(cellReq), .cellIn(cellIn),
        .cellAck(cellAck), .bufFree(bufFree), .bufBit(bufBit),
        .bufVal(bufVal), .bufAddr(bufAddr), .bufErr(bufErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [0:15] ack;
        logic [0:6]  bitv;
        logic [0:6]  val;
        logic [27:0] addr;
        logic [0:6]  err;
    } out_t;

    out_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    bit   force5   = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: each binding is a grant time g; samples at edges
    // g+2 .. g+1+XL, channel reusable at edge g+1+XL, cell free after it.
    longint cyc = 0;
    bit     m_act [7];
    int     m_src [7];
    longint m_g   [7];
    bit     m_par [7];
    int     m_rr;
    logic [27:0] m_addr;
    bit     bnd [16];
    bit     av  [7];

    always @(posedge clk) begin
        out_t e;
        int w, t, idx;
        logic b;
        e = '0;
        if (!rst_n) begin
            for (int k = 0; k < 7; k++) begin m_act[k] = 0; m_par[k] = 0; end
            m_rr   = 0;
            m_addr = '0;
        end else begin
            for (int c = 0; c < 16; c++) bnd[c] = 0;
            for (int k = 0; k < 7; k++) begin
                av[k] = !m_act[k] || (cyc == m_g[k] + 1 + XL);
                if (m_act[k]) bnd[m_src[k]] = 1;
            end
            for (int k = 0; k < 7; k++) begin
                if (m_act[k] && cyc >= m_g[k] + 2 && cyc <= m_g[k] + 1 + XL) begin
                    idx = int'(cyc - m_g[k] - 2);
                    b   = cellIn[m_src[k]];
                    if (idx < MSG_LEN) begin
                        e.bitv[k] = b;
                        e.val[k]  = 1'b1;
                        m_par[k]  = m_par[k] ^ b;
                    end else begin
                        e.err[k] = m_par[k] ^ b;
                    end
                    if (cyc == m_g[k] + 1 + XL) m_act[k] = 0;
                end
            end
            w = -1;
            for (int j = 0; j < 16; j++) begin
                idx = (m_rr + j) % 16;
                if (w < 0 && cellReq[idx] && !bnd[idx]) w = idx;
            end
            t = -1;
            for (int k = 0; k < 7; k++)
                if (t < 0 && av[k] && bufFree[k]) t = k;
            if (w >= 0 && t >= 0) begin
                m_act[t] = 1;
                m_src[t] = w;
                m_g[t]   = cyc;
                m_par[t] = 0;
                m_addr[4*t +: 4] = 4'(w);
                e.ack[w] = 1'b1;
                m_rr = (w + 1) % 16;
            end
        end
        e.addr = m_addr;
        sbq.push_back(e);
        cyc++;
    end

    // Monitor: compare every registered output cycle against the model
    initial begin
        out_t exp, got;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                exp = sbq.pop_front();
                got = '{ack: cellAck, bitv: bufBit, val: bufVal, addr: bufAddr, err: bufErr};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL outputs t=%0t got ack=%h bit=%h val=%h addr=%h err=%h exp ack=%h bit=%h val=%h addr=%h err=%h",
                             $time, got.ack, got.bitv, got.val, got.addr, got.err,
                             exp.ack, exp.bitv, exp.val, exp.addr, exp.err);
                end
            end
        end
    end

    // Behavioural cells: after an ack, drive bit 0 in the following cycle
    int              pos  [16];
    logic [MSG_LEN-1:0] msg [16];
    logic            flip [16];
    initial begin
        for (int c = 0; c < 16; c++) pos[c] = -2;
        cellIn = '0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 16; c++) begin
                if (!rst_n) begin
                    pos[c] = -2;
                end else begin
                    if (pos[c] >= -1) pos[c]++;
                    if (pos[c] >= XL) pos[c] = -2;
                    if (cellAck[c]) begin
                        pos[c]  = -1;
                        msg[c]  = (c == 5 && force5) ? 32'hA5A5F00F : MSG_LEN'($urandom);
                        flip[c] = ($urandom_range(0, 3) == 0);
                    end
                end
                if (pos[c] >= 0 && pos[c] < MSG_LEN)
                    cellIn[c] = msg[c][pos[c]];
                else if (pos[c] == MSG_LEN)
                    cellIn[c] = (^msg[c]) ^ flip[c];
                else
                    cellIn[c] = 1'($urandom);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stimulus
    initial begin
        logic [MSG_LEN-1:0] word;
        int got_bits, val_cycles;
        rst_n   = 1'b0;
        cellReq = '0;
        bufFree = '0;
        cycles(3);
        chk("reset_ack",  64'(cellAck), 64'd0);
        chk("reset_buf",  64'({bufBit, bufVal, bufErr}), 64'd0);
        chk("reset_addr", 64'(bufAddr), 64'd0);
        rst_n = 1'b1;
        cycles(2);

        // Single request from cell 5 with a known pattern
        force5     = 1'b1;
        bufFree    = 7'b1111111;
        cellReq[5] = 1'b1;
        cycles(1);
        chk("single_ack5",  64'(cellAck[5]), 64'd1);
        chk("single_addr0", 64'(bufAddr[3:0]), 64'd5);
        cellReq[5] = 1'b0;
        word = '0; got_bits = 0; val_cycles = 0;
        for (int n = 0; n < XL + 6; n++) begin
            @(negedge clk);
            if (bufVal[0]) begin
                if (got_bits < MSG_LEN) word[got_bits] = bufBit[0];
                got_bits++;
                val_cycles++;
            end
        end
        chk("single_pattern", 64'(word), 64'hA5A5F00F);
        chk("single_vallen",  64'(val_cycles), 64'(MSG_LEN));
        force5 = 1'b0;

        // Round robin among cells 0, 3, 15 held high across completions
        cellReq = '0;
        cellReq[0] = 1'b1; cellReq[3] = 1'b1; cellReq[15] = 1'b1;
        cycles(XL + 12);
        cellReq = '0;
        cycles(2 * XL + 8);

        // Buffer exhaustion with every cell requesting
        cellReq = '1;
        cycles(2 * XL + 20);
        cellReq = '0;
        cycles(XL + 8);

        // Partial availability, then drop a bound channel's bufFree
        bufFree = 7'b0010100;
        cellReq[7] = 1'b1; cellReq[9] = 1'b1;
        cycles(4);
        cellReq = '0;
        cycles(6);
        bufFree[2] = 1'b0;
        cycles(XL + 6);
        bufFree = 7'b1111111;

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            cellReq = 16'($urandom & $urandom & $urandom);
            bufFree = 7'($urandom | $urandom);
            cycles($urandom_range(1, 12));
        end
        cellReq = '0;
        bufFree = 7'b1111111;
        cycles(XL + 8);

        // Reset in the middle of a transfer
        cellReq[1] = 1'b1;
        cycles(1);
        cellReq[1] = 1'b0;
        cycles(11);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ack",  64'(cellAck), 64'd0);
        chk("midrst_buf",  64'({bufBit, bufVal, bufErr}), 64'd0);
        chk("midrst_addr", 64'(bufAddr), 64'd0);
        cycles(3);
        rst_n = 1'b1;
        cycles(1);
        cellReq[8] = 1'b1;
        cycles(1);
        chk("post_rst_ack8", 64'(cellAck[8]), 64'd1);
        cellReq = '0;
        cycles(XL + 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cell_collector.md
# cell_collector

Bit-serial collector on the cell-to-router side of the router: the inbound counterpart of the router-to-cell output path. It arbitrates among 16 cells requesting injection, binds each winner to one of 7 free router buffers, then forwards that cell's serial message bits, tagged with the source cell address, into the bound buffer. It sits between the 16 cell output lines and the buffer write ports.

## Interface
- `MSG_LEN`, 32: data bits per message, ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cellReq`  in  [0:15]  per-cell injection request, level.
- `cellIn`  in  [0:15]  per-cell serial message bit.
- `cellAck`  out  [0:15]  one-cycle grant pulse to a cell.
- `bufFree`  in  [0:6]  buffer k can accept a new message.
- `bufBit`  out  [0:6]  serial bit to buffer k.
- `bufVal`  out  [0:6]  `bufBit[k]` valid this cycle.
- `bufAddr`  out  [27:0]  source cell of channel k in bits [4k+3:4k]; held while the channel is bound.
- `bufErr`  out  [0:6]  parity-error pulse; see Configuration.

## Operation
- Seven channels, one per buffer. Each channel has three states: IDLE, ACK, XFER.
- Allocation: at most one new binding per cycle.
  - Eligible cells: `cellReq` high and not bound to any channel.
  - Winner: round-robin from pointer `rr` (0..15, wraps 15→0).
  - Target: the lowest-index channel that is IDLE with `bufFree[k]` high.
  - No eligible cell or no target: nothing happens, and `rr` is unchanged.
  - On a grant: `rr` ← winner+1 mod 16, the channel enters ACK, and `bufAddr` field k ← winner.
- ACK, one cycle: `cellAck[winner]`=1, then the channel moves to XFER with bit counter = 0.
- XFER, cycle by cycle:
  - Sample `cellIn[src]` each cycle.
  - Next cycle: drive `bufBit[k]` with the sample and `bufVal[k]`=1.
  - Counter increments; it is `$clog2(MSG_LEN+1)` bits wide.
  - After the last bit is sampled, the channel returns to IDLE.
- `bufFree` is ignored once a channel is bound.
- `cellReq` is ignored for bound cells. A request still high after the channel returns to IDLE counts as a new request.

## Timing
- A request sampled high at edge t with a target available gives `cellAck` high during cycle t+1 (registered).
- The cell drives bit 0 during cycle t+2 and bit i during cycle t+2+i.
- Bit i appears on `bufBit`/`bufVal` during cycle t+3+i: one cycle of latency, and `bufVal` is contiguous for the whole message.
- The channel is IDLE from the cycle after the last bit is sampled. It is eligible for allocation at that edge; that is back-to-back reuse.
- A channel finishing and a new grant to another channel in the same cycle are independent.
- Reset values: all outputs 0, all channels IDLE, `rr`=0, `bufAddr`=0.
- Reset asserted mid-transfer aborts every channel immediately. Partial messages are not completed.

## Configuration
- `CELL_COLLECTOR_PARITY_EN` defined:
  - Each message carries one extra even-parity bit after the MSG_LEN data bits, so XFER lasts MSG_LEN+1 cycles.
  - The parity bit is not forwarded.
  - `bufErr[k]` pulses high in the cycle after the parity bit is sampled if the XOR of data bits and parity bit is 1.
- Not defined: XFER lasts MSG_LEN cycles and `bufErr` is constant 0.

## Test plan
- Single request, MSG_LEN=32: cell 5 raises req at edge 0 with all bufFree=1.
  - Required: `cellAck[5]` during cycle 1, channel 0 bound, and `bufAddr[3:0]`=5.
  - Required: pattern 0xA5A5F00F shifted in appears bit-exact on `bufBit[0]` over cycles 3..34 with `bufVal[0]` high throughout.
- Round-robin: cells 0, 3 and 15 request simultaneously, `rr`=0.
  - Required: acks in consecutive cycles in the order 0, 3, 15, bound to channels 0, 1, 2.
  - Required: cell 0 requests again after finishing and is served after 3 and 15.
- Buffer exhaustion: all 16 cells request and `bufFree`=7'b1111111.
  - Required: exactly 7 acks, then none until a channel finishes.
  - Required: the next ack lands in the cycle after that channel's last bit sample.
- Partial availability: `bufFree`=7'b0010100 (only buffers 2 and 4 free) and two cells request.
  - Required: bindings to channels 2 then 4.
  - Required: dropping `bufFree[2]` mid-transfer does not disturb channel 2.
- Reset mid-transfer: assert `rst_n`=0 at bit 10 of an active message.
  - Required: all outputs 0 and `bufVal` low from that instant.
  - Required: after release, a new request is acked 1 cycle after it is sampled.
- With `CELL_COLLECTOR_PARITY_EN`: send one message with correct parity, then one with the parity bit flipped.
  - Required: `bufErr` stays 0 for the first.
  - Required: one `bufErr[k]` pulse for the second, in the cycle after its parity bit is sampled.
